// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the MPMC11 cache-fill path.
package mpmc11_pkg;

  localparam int unsigned MPMC11_LINE_BYTES = 32;

  typedef enum logic [3:0] {
    MC_IDLE     = 4'd0,
    PRESET0     = 4'd1,
    PRESET1     = 4'd2,
    PRESET2     = 4'd3,
    READ_CMD    = 4'd4,
    READ_DATA0  = 4'd5,
    READ_DATA1  = 4'd6,
    WRITE_DATA0 = 4'd7,
    WRITE_DATA1 = 4'd8,
    REFRESH     = 4'd9
  } mpmc11_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } mpmc11_fill_state_t;

endpackage

// File: rtl/mpmc11_byte_parity.sv
// Combinational even parity per byte: bit i is the XOR of byte i of data.
module mpmc11_byte_parity #(
  parameter int unsigned LINE_W = 256
) (
  input  logic [LINE_W-1:0]   data,
  output logic [LINE_W/8-1:0] par
);

  for (genvar i = 0; i < LINE_W / 8; i++) begin : g_byte
    assign par[i] = ^data[8*i +: 8];
  end

endmodule

// File: rtl/mpmc11_cache_fill.sv
// Captures memory read beats into cache line writes during a controller read burst.
// Optional byte parity output wpar is enabled with MPMC11_FILL_PARITY_EN.
module mpmc11_cache_fill
  import mpmc11_pkg::*;
#(
  parameter int unsigned LINE_W  = 256,
  parameter logic [7:0]  SAT_MAX = 8'hFF
) (
  input  logic                clk,
  input  logic                rst,
  input  mpmc11_state_t       state,
  input  logic                valid,
  input  logic [LINE_W-1:0]   rdata,
  input  logic [31:0]         addr,
  input  logic [7:0]          burst_len,
  output logic                wr,
  output logic [31:0]         wadr,
  output logic [LINE_W-1:0]   wdat,
  output logic [LINE_W/8-1:0] wsel,
  output logic                busy,
  output logic                fill_done,
  output logic [7:0]          beat_cnt,
  output logic [7:0]          discard_cnt
`ifdef MPMC11_FILL_PARITY_EN
  ,
  output logic [LINE_W/8-1:0] wpar
`endif
);

  localparam int unsigned OffW = $clog2(MPMC11_LINE_BYTES);

  mpmc11_fill_state_t fill_q, fill_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [7:0]          discard_q;
  logic                wr_q, done_q;
  logic [31:0]         wadr_q;
  logic [LINE_W-1:0]   wdat_q;
  logic [LINE_W/8-1:0] wsel_q;
  logic                accept, last, discard;

  // Line-offset and top address bits are dropped when forming the line address.
  logic unused_addr;
  assign unused_addr = ^{addr[31:30], addr[OffW-1:0]};

  always_comb begin
    fill_d  = fill_q;
    len_d   = len_q;
    beat_d  = beat_q;
    accept  = 1'b0;
    last    = 1'b0;
    discard = 1'b0;
    case (fill_q)
      IDLE: begin
        discard = valid;
        if (state == PRESET2) begin
          fill_d = ARMED;
          len_d  = burst_len;
          beat_d = '0;
        end
      end
      ARMED: begin
        discard = valid;
        if (state == PRESET2) begin
          len_d  = burst_len;
          beat_d = '0;
        end else if (state == READ_DATA0) begin
          fill_d = FILL;
        end
      end
      FILL: begin
        // A new PRESET2 abandons the partial line; the beat in that cycle is dropped.
        if (state == PRESET2) begin
          fill_d  = ARMED;
          len_d   = burst_len;
          beat_d  = '0;
          discard = valid;
        end else if (valid) begin
          accept = 1'b1;
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) begin
            last   = 1'b1;
            fill_d = DONE;
          end
        end
      end
      DONE: begin
        discard = valid;
        if (state == PRESET2) begin
          fill_d = ARMED;
          len_d  = burst_len;
          beat_d = '0;
        end else begin
          fill_d = IDLE;
        end
      end
      default: fill_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q    <= IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      discard_q <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      wadr_q    <= '0;
      wdat_q    <= '0;
      wsel_q    <= '0;
    end else begin
      fill_q <= fill_d;
      len_q  <= len_d;
      beat_q <= beat_d;
      wr_q   <= accept;
      done_q <= last;
      if (discard && (discard_q < SAT_MAX)) begin
        discard_q <= discard_q + 8'd1;
      end
      if (accept) begin
        wadr_q <= {2'b00, addr[29:OffW], {OffW{1'b0}}};
        wdat_q <= rdata;
        wsel_q <= '1;
      end
    end
  end

`ifdef MPMC11_FILL_PARITY_EN
  logic [LINE_W/8-1:0] par_comb;
  logic [LINE_W/8-1:0] wpar_q;

  mpmc11_byte_parity #(
    .LINE_W(LINE_W)
  ) u_byte_parity (
    .data(rdata),
    .par (par_comb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wpar_q <= '0;
    end else if (accept) begin
      wpar_q <= par_comb;
    end
  end

  assign wpar = wpar_q;
`endif

  assign wr          = wr_q;
  assign wadr        = wadr_q;
  assign wdat        = wdat_q;
  assign wsel        = wsel_q;
  assign fill_done   = done_q;
  assign beat_cnt    = beat_q;
  assign discard_cnt = discard_q;
  assign busy        = (fill_q == ARMED) || (fill_q == FILL);

endmodule

// File: tb/tb_mpmc11_cache_fill.sv
// Scoreboard bench for mpmc11_cache_fill: directed fills, aborts, resets and discard saturation.
module tb_mpmc11_cache_fill;
  import mpmc11_pkg::*;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned NB     = LINE_W / 8;

  // Every byte of these patterns has an even number of ones, so their parity is zero.
  localparam logic [LINE_W-1:0] D0 = {8{32'h1111_0000}};
  localparam logic [LINE_W-1:0] D1 = {8{32'h3333_A5A5}};
  localparam logic [LINE_W-1:0] D2 = {8{32'h3C3C_0011}};
  localparam logic [LINE_W-1:0] D3 = {8{32'hFFFF_0000}};
  localparam logic [LINE_W-1:0] D7 = 256'h07;

  logic                clk = 1'b0;
  logic                rst;
  mpmc11_state_t       state;
  logic                valid;
  logic [LINE_W-1:0]   rdata;
  logic [31:0]         addr;
  logic [7:0]          burst_len;
  logic                wr;
  logic [31:0]         wadr;
  logic [LINE_W-1:0]   wdat;
  logic [NB-1:0]       wsel;
  logic                busy;
  logic                fill_done;
  logic [7:0]          beat_cnt;
  logic [7:0]          discard_cnt;
`ifdef MPMC11_FILL_PARITY_EN
  logic [NB-1:0]       wpar;
`endif

  mpmc11_cache_fill #(
    .LINE_W (LINE_W),
    .SAT_MAX(8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .valid      (valid),
    .rdata      (rdata),
    .addr       (addr),
    .burst_len  (burst_len),
    .wr         (wr),
    .wadr       (wadr),
    .wdat       (wdat),
    .wsel       (wsel),
    .busy       (busy),
    .fill_done  (fill_done),
    .beat_cnt   (beat_cnt),
    .discard_cnt(discard_cnt)
`ifdef MPMC11_FILL_PARITY_EN
    ,
    .wpar       (wpar)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       adr;
    logic [LINE_W-1:0] dat;
    logic [NB-1:0]     par;
    logic              done;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  logic [NB-1:0] all_sel;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every wr pops one expected write; fill_done must never appear without wr.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wr", LINE_W'(wr), LINE_W'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("wadr", LINE_W'(wadr), LINE_W'(e.adr));
          check("wdat", wdat, e.dat);
          check("wsel", LINE_W'(wsel), LINE_W'(all_sel));
          check("fill_done_with_wr", LINE_W'(fill_done), LINE_W'(e.done));
`ifdef MPMC11_FILL_PARITY_EN
          check("wpar", LINE_W'(wpar), LINE_W'(e.par));
`endif
        end
      end else begin
        check("fill_done_without_wr", LINE_W'(fill_done), LINE_W'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [7:0] len);
    state     = PRESET2;
    burst_len = len;
    tick();
    state = READ_DATA0;
    tick();
    state = MC_IDLE;
  endtask

  // One valid beat; when acc is set the expected line write is queued first.
  task automatic beat(input logic [31:0] a, input logic [LINE_W-1:0] d, input bit acc,
                      input logic [31:0] exp_adr, input logic [NB-1:0] exp_par,
                      input bit done);
    exp_t e;
    if (acc) begin
      e.adr  = exp_adr;
      e.dat  = d;
      e.par  = exp_par;
      e.done = done;
      sb_q.push_back(e);
    end
    valid = 1'b1;
    addr  = a;
    rdata = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("scoreboard_drained", LINE_W'(sb_q.size()), LINE_W'(0));
  endtask

  task automatic four_beats(input logic [31:0] base);
    beat(base,          D0, 1'b1, base,          '0, 1'b0);
    beat(base + 32'h20, D1, 1'b1, base + 32'h20, '0, 1'b0);
    beat(base + 32'h40, D2, 1'b1, base + 32'h40, '0, 1'b0);
    beat(base + 32'h60, D3, 1'b1, base + 32'h60, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    all_sel   = '1;
    rst       = 1'b1;
    state     = MC_IDLE;
    valid     = 1'b0;
    rdata     = '0;
    addr      = '0;
    burst_len = '0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_wr", LINE_W'(wr), LINE_W'(0));
    check("rst_busy", LINE_W'(busy), LINE_W'(0));
    check("rst_fill_done", LINE_W'(fill_done), LINE_W'(0));
    check("rst_wadr", LINE_W'(wadr), LINE_W'(0));
    check("rst_wsel", LINE_W'(wsel), LINE_W'(0));
    check("rst_beat_cnt", LINE_W'(beat_cnt), LINE_W'(0));
    check("rst_discard_cnt", LINE_W'(discard_cnt), LINE_W'(0));
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // Basic 4-beat fill at 0x100..0x160.
    arm(8'd3);
    @(negedge clk);
    check("armed_busy", LINE_W'(busy), LINE_W'(1));
    four_beats(32'h100);
    drain();
    @(negedge clk);
    check("t1_beat_cnt", LINE_W'(beat_cnt), LINE_W'(4));
    check("t1_busy_after", LINE_W'(busy), LINE_W'(0));
    check("t1_discard_cnt", LINE_W'(discard_cnt), LINE_W'(0));

    // Same fill followed by two surplus beats, which are dropped.
    arm(8'd3);
    four_beats(32'h100);
    beat(32'h180, D0, 1'b0, 32'h0, '0, 1'b0);
    beat(32'h1A0, D1, 1'b0, 32'h0, '0, 1'b0);
    drain();
    @(negedge clk);
    check("t2_beat_cnt", LINE_W'(beat_cnt), LINE_W'(4));
    check("t2_discard_cnt", LINE_W'(discard_cnt), LINE_W'(2));

    // Single-beat fill; upper address bits are stripped.
    arm(8'd0);
    beat(32'hC000_0040, D2, 1'b1, 32'h0000_0040, '0, 1'b1);
    drain();
    @(negedge clk);
    check("t3_beat_cnt", LINE_W'(beat_cnt), LINE_W'(1));

    // Abort after two beats, then a complete fill.
    arm(8'd3);
    beat(32'h200, D0, 1'b1, 32'h200, '0, 1'b0);
    beat(32'h220, D1, 1'b1, 32'h220, '0, 1'b0);
    state = PRESET2;
    tick();
    state = MC_IDLE;
    @(negedge clk);
    check("t4_beat_cnt_cleared", LINE_W'(beat_cnt), LINE_W'(0));
    check("t4_rearmed_busy", LINE_W'(busy), LINE_W'(1));
    state = READ_DATA0;
    tick();
    state = MC_IDLE;
    four_beats(32'h300);
    drain();
    @(negedge clk);
    check("t4_beat_cnt", LINE_W'(beat_cnt), LINE_W'(4));

    // Reset one beat into a fill; following beats are discarded until re-armed.
    arm(8'd3);
    beat(32'h400, D3, 1'b1, 32'h400, '0, 1'b0);
    rst   = 1'b1;
    valid = 1'b1;
    addr  = 32'h420;
    rdata = D0;
    tick();
    @(negedge clk);
    check("t5_wr", LINE_W'(wr), LINE_W'(0));
    check("t5_wadr", LINE_W'(wadr), LINE_W'(0));
    check("t5_wdat", wdat, LINE_W'(0));
    check("t5_wsel", LINE_W'(wsel), LINE_W'(0));
    check("t5_busy", LINE_W'(busy), LINE_W'(0));
    check("t5_beat_cnt", LINE_W'(beat_cnt), LINE_W'(0));
    check("t5_discard_cnt", LINE_W'(discard_cnt), LINE_W'(0));
    rst = 1'b0;
    repeat (2) tick();
    valid = 1'b0;
    @(negedge clk);
    check("t5_discard_after", LINE_W'(discard_cnt), LINE_W'(2));
    arm(8'd0);
    beat(32'h440, D1, 1'b1, 32'h440, '0, 1'b1);
    drain();

    // Parity of byte 0 = 0x07 is 1, all other bytes 0.
    arm(8'd0);
    beat(32'h500, D7, 1'b1, 32'h500, 32'h0000_0001, 1'b1);
    drain();

    // Discard counter saturates.
    valid = 1'b1;
    repeat (260) tick();
    valid = 1'b0;
    @(negedge clk);
    check("sat_discard_cnt", LINE_W'(discard_cnt), LINE_W'(8'hFF));
    valid = 1'b1;
    tick();
    valid = 1'b0;
    @(negedge clk);
    check("sat_hold", LINE_W'(discard_cnt), LINE_W'(8'hFF));
    drain();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
